vga_timing_core: RTL and testbench

Generates 640×480@60 Hz VGA timing from the 50 MHz system clock. It divides the system clock to a 25 MHz pixel rate, runs the horizontal and vertical counters, and produces the following:
- sync and blanking signals;
- the current pixel address, sent to the pixel generator;
- 8-bit-per-channel colour, expanded from the 12-bit pixel the generator returns.

It sits between the drawing logic, such as the clock-face renderer, and the board's VGA DAC pins.

---
 rtl/vga_pkg.sv | 16 +
 rtl/pix_clk_div.sv | 40 ++++
 rtl/vga_timing_core.sv | 76 +++++++
 tb/tb_vga_timing_core.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 Hz timing constants and pixel type
package vga_pkg;

   localparam int unsigned H_SYNC      = 96;
   localparam int unsigned H_ACT_START = 144;
   localparam int unsigned H_ACT_END   = 784;
   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_SYNC      = 2;
   localparam int unsigned V_ACT_START = 35;
   localparam int unsigned V_ACT_END   = 515;
   localparam int unsigned V_TOTAL     = 525;

   // {R[11:8], G[7:4], B[3:0]}
   typedef logic [11:0] pixel_t;

endpackage

// File: rtl/pix_clk_div.sv
// rtl/pix_clk_div.sv - divides clk by DIV into a 50% duty pixel clock and a one-cycle pixel enable
module pix_clk_div #(
   parameter int unsigned DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clk_en,
   output logic o_vga_clk,
   output logic o_pix_en
);

   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] TC = CW'(HALF - 1);

   logic [CW-1:0] r_cnt;
   logic          r_vga_clk;
   logic          w_tc;

   assign w_tc = i_clk_en && (r_cnt == TC);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_vga_clk <= 1'b0;
      end else if (i_clk_en) begin
         if (r_cnt == TC) begin
            r_cnt     <= '0;
            r_vga_clk <= ~r_vga_clk;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Enable coincides with the 0->1 toggle so pixels advance on the DAC clock rising edge
   assign o_pix_en  = w_tc && !r_vga_clk;
   assign o_vga_clk = r_vga_clk;

endmodule

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - VGA 640x480 counters, sync/blank decode, pixel address and colour expansion
module vga_timing_core
   import vga_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned PIX_FREQ = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  pixel_t     vga_data,
   output logic       vga_clk,
   output logic [9:0] h_addr,
   output logic [9:0] v_addr,
   output logic       hsync,
   output logic       vsync,
   output logic       valid,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b
);

   localparam int unsigned DIV = CLK_FREQ / PIX_FREQ;

   logic [9:0] r_hcnt;
   logic [9:0] r_vcnt;
   logic       w_pix_en;
   logic       w_h_last;
   logic       w_v_last;
   logic       w_h_valid;
   logic       w_v_valid;
   logic       w_valid;

   pix_clk_div #(
      .DIV (DIV)
   ) u_div (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_clk_en  (clk_en),
      .o_vga_clk (vga_clk),
      .o_pix_en  (w_pix_en)
   );

   assign w_h_last = (r_hcnt == 10'(H_TOTAL - 1));
   assign w_v_last = (r_vcnt == 10'(V_TOTAL - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_pix_en) begin
         if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;
         end else begin
            r_hcnt <= r_hcnt + 10'd1;
         end
      end
   end

   assign w_h_valid = (r_hcnt >= 10'(H_ACT_START)) && (r_hcnt < 10'(H_ACT_END));
   assign w_v_valid = (r_vcnt >= 10'(V_ACT_START)) && (r_vcnt < 10'(V_ACT_END));
   assign w_valid   = w_h_valid && w_v_valid;

   assign hsync  = (r_hcnt >= 10'(H_SYNC));
   assign vsync  = (r_vcnt >= 10'(V_SYNC));
   assign valid  = w_valid;
   assign h_addr = w_valid ? (r_hcnt - 10'(H_ACT_START)) : 10'd0;
   assign v_addr = w_valid ? (r_vcnt - 10'(V_ACT_START)) : 10'd0;

   // Nibble replication maps 0x0..0xF onto the full 0x00..0xFF DAC range
   assign vga_r = w_valid ? {vga_data[11:8], vga_data[11:8]} : 8'd0;
   assign vga_g = w_valid ? {vga_data[7:4],  vga_data[7:4]}  : 8'd0;
   assign vga_b = w_valid ? {vga_data[3:0],  vga_data[3:0]}  : 8'd0;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb/tb_vga_timing_core.sv - self-checking bench for vga_timing_core against an arithmetic pixel model
module tb_vga_timing_core;

   localparam int unsigned CLK_FREQ = 50_000_000;
   localparam int unsigned PIX_FREQ = 25_000_000;
   localparam int unsigned DIV      = CLK_FREQ / PIX_FREQ;
   localparam int unsigned HALF     = DIV / 2;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic [11:0] vga_data;
   logic        vga_clk;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic        hsync;
   logic        vsync;
   logic        valid;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;

   int n_en;
   int n_checks;
   int n_fail;

   logic [23:0] w_obs;
   logic [23:0] w_col;
   assign w_obs = {vga_clk, hsync, vsync, valid, h_addr, v_addr};
   assign w_col = {vga_r, vga_g, vga_b};

   vga_timing_core #(
      .CLK_FREQ (CLK_FREQ),
      .PIX_FREQ (PIX_FREQ)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .vga_data (vga_data),
      .vga_clk  (vga_clk),
      .h_addr   (h_addr),
      .v_addr   (v_addr),
      .hsync    (hsync),
      .vsync    (vsync),
      .valid    (valid),
      .vga_r    (vga_r),
      .vga_g    (vga_g),
      .vga_b    (vga_b)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Expected {vga_clk, hsync, vsync, valid, h_addr, v_addr} after n enabled clk edges since release
   function automatic logic [23:0] model(input int n);
      int p;
      int h;
      int v;
      logic hs, vs, val, vc;
      logic [9:0] ha, va;
      p   = (n >= int'(HALF)) ? (n - int'(HALF)) / int'(DIV) + 1 : 0;
      h   = p % 800;
      v   = (p / 800) % 525;
      hs  = (h >= 96);
      vs  = (v >= 2);
      val = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
      ha  = val ? 10'(h - 144) : 10'd0;
      va  = val ? 10'(v - 35) : 10'd0;
      vc  = ((n / int'(HALF)) % 2) == 1;
      return {vc, hs, vs, val, ha, va};
   endfunction

   function automatic logic [23:0] colour(input logic val, input logic [11:0] d);
      int r, g, b;
      r = int'(d[11:8]) * 17;
      g = int'(d[7:4]) * 17;
      b = int'(d[3:0]) * 17;
      return val ? {8'(r), 8'(g), 8'(b)} : 24'd0;
   endfunction

   task automatic tick(input logic en);
      clk_en   = en;
      vga_data = 12'($urandom);
      @(posedge clk);
      if (en) n_en++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [23:0] exp;
      rst      = 1'b0;
      clk_en   = 1'b1;
      vga_data = 12'hFFF;
      #1;
      n_checks++;
      if ({w_obs, w_col} !== 48'd0) begin
         n_fail++;
         $display("FAIL reset_async got=%h required=0", {w_obs, w_col});
      end
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         vga_data = 12'hFFF;
         #1;
         n_checks++;
         if ({w_obs, w_col} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h required=0", {w_obs, w_col});
         end
      end
      @(negedge clk);
      rst  = 1'b1;
      n_en = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1);
         exp = model(n_en);
         n_checks++;
         if (vga_clk !== (i % 2 == 0)) begin
            n_fail++;
            $display("FAIL release_vga_clk cycle=%0d got=%b required=%b", i + 1, vga_clk, (i % 2 == 0));
         end
         n_checks++;
         if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL release_timing n=%0d got=%h required=%h", n_en, w_obs, exp);
         end
      end
   endtask

   task automatic test_horizontal();
      logic [23:0] exp;
      logic prev_hs, prev_vs, prev_vc;
      int rises, falls;
      prev_hs = hsync;
      prev_vs = vsync;
      prev_vc = vga_clk;
      rises   = 0;
      falls   = 0;
      for (int i = 0; i < 3300; i++) begin
         tick(1'b1);
         exp = model(n_en);
         n_checks++;
         if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL h_timing n=%0d got=%h required=%h", n_en, w_obs, exp);
         end
         n_checks++;
         if (w_col !== colour(exp[20], vga_data)) begin
            n_fail++;
            $display("FAIL h_colour n=%0d got=%h required=%h", n_en, w_col, colour(exp[20], vga_data));
         end
         if (vga_clk && !prev_vc) rises++;
         if (!hsync && prev_hs) begin
            if (falls > 0) begin
               n_checks++;
               if (rises !== 800) begin
                  n_fail++;
                  $display("FAIL line_length got=%0d required=800", rises);
               end
            end
            falls++;
            rises = 0;
         end
         if (hsync && !prev_hs && falls > 0) begin
            n_checks++;
            if (rises !== 96) begin
               n_fail++;
               $display("FAIL hsync_width got=%0d required=96", rises);
            end
         end
         if (vsync && !prev_vs) begin
            n_checks++;
            if (falls !== 2) begin
               n_fail++;
               $display("FAIL vsync_width got=%0d lines required=2", falls);
            end
         end
         prev_hs = hsync;
         prev_vs = vsync;
         prev_vc = vga_clk;
      end
      n_checks++;
      if (falls !== 2) begin
         n_fail++;
         $display("FAIL hsync_falls got=%0d required=2", falls);
      end
   endtask

   task automatic test_vertical();
      logic [23:0] exp;
      logic prev_hs, prev_vc, prev_valid;
      logic [9:0] prev_haddr;
      int rises, lines;
      prev_hs    = hsync;
      prev_vc    = vga_clk;
      prev_valid = valid;
      prev_haddr = h_addr;
      rises      = 0;
      lines      = 0;
      while (n_en < int'(DIV) * (37 * 800 + 400)) begin
         tick(1'b1);
         exp = model(n_en);
         n_checks++;
         if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL v_timing n=%0d got=%h required=%h", n_en, w_obs, exp);
         end
         n_checks++;
         if (w_col !== colour(exp[20], vga_data)) begin
            n_fail++;
            $display("FAIL v_colour n=%0d got=%h required=%h", n_en, w_col, colour(exp[20], vga_data));
         end
         if (vga_clk && !prev_vc) rises++;
         if (!hsync && prev_hs) rises = 0;
         if (valid && !prev_valid) begin
            n_checks++;
            if (rises !== 144 || h_addr !== 10'd0 || v_addr !== 10'(lines)) begin
               n_fail++;
               $display("FAIL valid_rise got=%0d/%0d/%0d required=144/0/%0d", rises, h_addr, v_addr, lines);
            end
            lines++;
         end
         if (!valid && prev_valid) begin
            n_checks++;
            if (prev_haddr !== 10'd639) begin
               n_fail++;
               $display("FAIL last_column got=%0d required=639", prev_haddr);
            end
         end
         prev_hs    = hsync;
         prev_vc    = vga_clk;
         prev_valid = valid;
         prev_haddr = h_addr;
      end
      n_checks++;
      if (lines !== 3) begin
         n_fail++;
         $display("FAIL active_lines got=%0d required=3", lines);
      end
   endtask

   task automatic test_clk_en();
      logic [23:0] exp;
      exp = model(n_en);
      n_checks++;
      if (h_addr !== 10'd256 || v_addr !== 10'd2) begin
         n_fail++;
         $display("FAIL pre_freeze_addr got=%0d,%0d required=256,2", h_addr, v_addr);
      end
      for (int i = 0; i < 37; i++) begin
         tick(1'b0);
         n_checks++;
         if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL freeze cycle=%0d got=%h required=%h", i, w_obs, exp);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick(1'b1);
         exp = model(n_en);
         n_checks++;
         if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL resume_timing n=%0d got=%h required=%h", n_en, w_obs, exp);
         end
         if (h_addr !== 10'd256) break;
      end
      n_checks++;
      if (h_addr !== 10'd257) begin
         n_fail++;
         $display("FAIL resume_addr got=%0d required=257", h_addr);
      end
   endtask

   task automatic test_colour();
      vga_data = 12'hF0F;
      #1;
      n_checks++;
      if (valid !== 1'b1 || w_col !== 24'hFF00FF) begin
         n_fail++;
         $display("FAIL colour_active got=%b/%h required=1/ff00ff", valid, w_col);
      end
      for (int i = 0; i < 2000; i++) begin
         tick(1'b1);
         if (model(n_en)[20] == 1'b0) break;
      end
      vga_data = 12'hFFF;
      #1;
      n_checks++;
      if (valid !== 1'b0 || w_col !== 24'd0) begin
         n_fail++;
         $display("FAIL colour_blank got=%b/%h required=0/000000", valid, w_col);
      end
   endtask

   task automatic test_async_reset();
      logic [23:0] exp;
      @(negedge clk);
      vga_data = 12'hFFF;
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({w_obs, w_col} !== 48'd0) begin
         n_fail++;
         $display("FAIL async_reset got=%h required=0", {w_obs, w_col});
      end
      @(negedge clk);
      rst = 1'b1;
      n_en = 0;
      for (int i = 0; i < 2000; i++) begin
         tick(1'b1);
         exp = model(n_en);
         n_checks++;
         if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL restart_timing n=%0d got=%h required=%h", n_en, w_obs, exp);
         end
      end
   endtask

   initial begin
      n_en     = 0;
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_horizontal();
      test_vertical();
      test_clk_en();
      test_colour();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
